// File: rtl/note_cmd_rx_if.sv
// note_cmd_rx_if: serial input, enable and decoded note outputs of the note command receiver
interface note_cmd_rx_if;
    logic       rx_enable;
    logic       rx;
    logic [7:0] rx_byte;
    logic       rx_byte_valid;
    logic       framing_err;
    logic [3:0] pitch;
    logic [1:0] octave;
    logic       note_valid;
    logic       parse_error;
    modport master (
        output rx_enable, rx,
        input  rx_byte, rx_byte_valid, framing_err, pitch, octave, note_valid, parse_error
    );
    modport slave (
        input  rx_enable, rx,
        output rx_byte, rx_byte_valid, framing_err, pitch, octave, note_valid, parse_error
    );
endinterface

// File: rtl/note_cmd_rx.sv
// note_cmd_rx: UART 8N1 receiver plus parser for "A#4, 466" style note command lines
module note_cmd_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int MAX_TAIL     = 8
) (
    input logic         clk,
    input logic         reset,
    note_cmd_rx_if.slave bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(MAX_TAIL + 1);
    // semitone of each letter, indexed by the low three bits of its ASCII code
    localparam logic [31:0] BASE = {4'd7, 4'd5, 4'd4, 4'd2, 4'd0, 4'd11, 4'd9, 4'd0};
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_t;
    typedef enum logic [2:0] {P_NOTE, P_ACC, P_OCT, P_TAIL, P_SKIP} p_state_t;
    logic [1:0]    sync;
    logic          rx_s;
    rx_state_t     rs, rs_nx;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          half_hit, full_hit, byte_done, frame_bad;
    assign rx_s     = sync[1];
    assign half_hit = cnt == CW'(CLKS_PER_BIT / 2 - 1);
    assign full_hit = cnt == CW'(CLKS_PER_BIT - 1);
    always_ff @(posedge clk)
        if (reset) begin
            sync <= 2'b11;
            rs   <= IDLE;
        end else begin
            sync <= {sync[0], bus.rx};
            rs   <= rs_nx;
        end
    always_comb begin
        rs_nx = rs;
        case (rs)
            IDLE:      rs_nx = rx_s ? IDLE : START;
            START:     rs_nx = !half_hit ? START : rx_s ? IDLE : DATA;
            DATA:      rs_nx = full_hit && bit_idx == 3'd7 ? STOP : DATA;
            STOP:      rs_nx = !full_hit ? STOP : rx_s ? IDLE : WAIT_HIGH;
            WAIT_HIGH: rs_nx = rx_s ? IDLE : WAIT_HIGH;
            default:   rs_nx = IDLE;
        endcase
        if (!bus.rx_enable) rs_nx = IDLE;
    end
    always_comb begin
        byte_done = rs == STOP && full_hit && rx_s && bus.rx_enable;
        frame_bad = rs == STOP && full_hit && !rx_s && bus.rx_enable;
    end
    always_ff @(posedge clk)
        if (reset) begin
            cnt               <= '0;
            bit_idx           <= 3'd0;
            shreg             <= 8'd0;
            bus.rx_byte       <= 8'd0;
            bus.rx_byte_valid <= 1'b0;
            bus.framing_err   <= 1'b0;
        end else begin
            cnt               <= (rs_nx != rs || full_hit) ? '0 : cnt + 1'b1;
            bit_idx           <= rs != DATA ? 3'd0 : bit_idx + 3'(full_hit);
            shreg             <= rs == DATA && full_hit ? {rx_s, shreg[7:1]} : shreg;
            bus.rx_byte       <= byte_done ? shreg : bus.rx_byte;
            bus.rx_byte_valid <= byte_done;
            bus.framing_err   <= frame_bad;
        end
    p_state_t      ps, ps_nx;
    logic [3:0]    sh_pitch;
    logic [1:0]    sh_oct;
    logic [TW-1:0] tail_cnt;
    logic [7:0]    b, lc;
    logic          vld, fe, is_term, is_letter, is_oct, is_sharp, commit, perr;
    assign b         = bus.rx_byte;
    assign vld       = bus.rx_byte_valid;
    assign fe        = bus.framing_err;
    assign lc        = b | 8'h20;
    assign is_letter = lc >= 8'h61 && lc <= 8'h67;
    assign is_oct    = b >= 8'h33 && b <= 8'h36;
    assign is_term   = b == 8'h0D || b == 8'h0A;
    assign is_sharp  = b == 8'h23;
    always_ff @(posedge clk)
        if (reset) ps <= P_NOTE;
        else ps <= ps_nx;
    always_comb begin
        ps_nx = ps;
        if (vld)
            case (ps)
                P_NOTE:  ps_nx = is_letter ? P_ACC : is_term ? P_NOTE : P_SKIP;
                P_ACC:   ps_nx = is_term ? P_NOTE
                               : is_sharp ? (sh_pitch == 4'd4 || sh_pitch == 4'd11 ? P_SKIP : P_OCT)
                               : b == 8'h20 ? P_OCT : is_oct ? P_TAIL : P_SKIP;
                P_OCT:   ps_nx = is_term ? P_NOTE : is_oct ? P_TAIL : P_SKIP;
                P_TAIL:  ps_nx = is_term ? P_NOTE : tail_cnt == TW'(MAX_TAIL) ? P_SKIP : P_TAIL;
                default: ps_nx = is_term ? P_NOTE : P_SKIP;
            endcase
        if (fe && ps != P_NOTE) ps_nx = P_SKIP;
    end
    always_comb begin
        commit = vld && is_term && ps == P_TAIL;
        perr   = vld && is_term && (ps == P_ACC || ps == P_OCT || ps == P_SKIP);
    end
    // candidate note lives in shadow registers until the terminator commits it
    always_ff @(posedge clk)
        if (reset) begin
            sh_pitch        <= 4'd9;
            sh_oct          <= 2'd1;
            tail_cnt        <= '0;
            bus.pitch       <= 4'd9;
            bus.octave      <= 2'd1;
            bus.note_valid  <= 1'b0;
            bus.parse_error <= 1'b0;
        end else begin
            if (vld) begin
                if (ps == P_NOTE && is_letter) sh_pitch <= BASE[{lc[2:0], 2'b00} +: 4];
                if (ps == P_ACC && is_sharp) sh_pitch <= sh_pitch + 4'd1;
                if ((ps == P_ACC || ps == P_OCT) && is_oct) sh_oct <= b[1:0] + 2'd1;
                tail_cnt <= ps == P_TAIL ? tail_cnt + 1'b1 : '0;
            end
            bus.pitch       <= commit ? sh_pitch : bus.pitch;
            bus.octave      <= commit ? sh_oct : bus.octave;
            bus.note_valid  <= commit;
            bus.parse_error <= perr;
        end
endmodule

// File: tb/tb_note_cmd_rx.sv
// tb_note_cmd_rx: vector table, directed corner sequences and random lines against a line-level model
module tb_note_cmd_rx;
    localparam int CPB = 32;
    localparam int MT  = 8;
    logic clk = 1'b0;
    logic reset = 1'b1;
    note_cmd_rx_if bus();
    note_cmd_rx #(.CLKS_PER_BIT(CPB), .MAX_TAIL(MT)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
    always #5 clk = ~clk;
    typedef struct {
        logic [95:0] txt;
        logic [7:0]  term;
        int          nv;
        int          pe;
        int          p;
        int          o;
    } vec_t;
    int checks = 0, errors = 0;
    int cyc = 0, last_vld = -10;
    int n_vld = 0, n_fe = 0, n_nv = 0, n_pe = 0;
    logic [7:0] blog[$];
    logic [6:0] evq[$], expq[$];
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    always @(posedge clk) cyc++;
    always @(negedge clk)
        if (!reset) begin
            if (bus.rx_byte_valid) begin
                n_vld++;
                blog.push_back(bus.rx_byte);
                last_vld = cyc;
            end
            if (bus.framing_err) n_fe++;
            if (bus.note_valid || bus.parse_error) begin
                check("pulse_latency", cyc - last_vld, 1);
                check("pulse_exclusive", int'(bus.note_valid && bus.parse_error), 0);
                if (bus.note_valid) begin
                    n_nv++;
                    evq.push_back({1'b1, bus.pitch, bus.octave});
                end else begin
                    n_pe++;
                    evq.push_back(7'd0);
                end
            end
        end
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic send_byte(input logic [7:0] v, input logic stop);
        bus.rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            bus.rx = v[i];
            idle(CPB);
        end
        bus.rx = stop;
        idle(CPB);
    endtask
    task automatic send_str(input logic [95:0] t, input logic [7:0] term);
        for (int k = 11; k >= 0; k--)
            if (t[8*k +: 8] != 8'd0) send_byte(t[8*k +: 8], 1'b1);
        send_byte(term, 1'b1);
        idle(4);
    endtask
    task automatic check_note(input string name, input int p, input int o);
        check({name, "_pitch"}, int'(bus.pitch), p);
        check({name, "_octave"}, int'(bus.octave), o);
    endtask
    // whole-line grammar: letter, optional '#' or ' ', octave 3..6, at most MT tail bytes
    function automatic void model_line(input logic [7:0] ln[$], output logic ok,
                                       output logic [3:0] p, output logic [1:0] o);
        int semis[7] = '{9, 11, 0, 2, 4, 5, 7};
        int i;
        logic [7:0] c;
        ok = 1'b0;
        p = 4'd0;
        o = 2'd0;
        c = (ln[0] >= "A" && ln[0] <= "G") ? ln[0] + 8'd32 : ln[0];
        if (c < "a" || c > "g") return;
        p = 4'(semis[c - "a"]);
        i = 1;
        if (i < ln.size() && ln[i] == 8'h23) begin
            if (p == 4'd4 || p == 4'd11) return;
            p++;
            i++;
        end else if (i < ln.size() && ln[i] == 8'h20) i++;
        if (i >= ln.size() || ln[i] < "3" || ln[i] > "6") return;
        o = 2'(ln[i] - "3");
        i++;
        ok = (ln.size() - i) <= MT;
    endfunction
    initial begin
        vec_t tbl[$];
        logic [7:0] eb[5] = '{8'h41, 8'h23, 8'h34, 8'h0D, 8'h0A};
        int v0, f0, nv0, pe0, mp, mo;
        string letters = "ABCDEFGHabcdefgz";
        tbl.push_back('{"A#4",         8'h0D, 1, 0, 10, 1});
        tbl.push_back('{96'd0,         8'h0A, 0, 0, 10, 1});
        tbl.push_back('{"C 3, 131",    8'h0D, 1, 0,  0, 0});
        tbl.push_back('{"B6",          8'h0A, 1, 0, 11, 3});
        tbl.push_back('{"E#5",         8'h0D, 0, 1, 11, 3});
        tbl.push_back('{"b#4",         8'h0D, 0, 1, 11, 3});
        tbl.push_back('{"g#5",         8'h0A, 1, 0,  8, 2});
        tbl.push_back('{"A4,1234567",  8'h0D, 1, 0,  9, 1});
        tbl.push_back('{"F3,12345678", 8'h0D, 0, 1,  9, 1});
        tbl.push_back('{"X4",          8'h0D, 0, 1,  9, 1});
        tbl.push_back('{"D",           8'h0D, 0, 1,  9, 1});
        tbl.push_back('{"D#",          8'h0A, 0, 1,  9, 1});
        tbl.push_back('{"C7",          8'h0D, 0, 1,  9, 1});
        tbl.push_back('{"A# 4",        8'h0D, 0, 1,  9, 1});
        tbl.push_back('{"E3",          8'h0D, 1, 0,  4, 0});
        bus.rx = 1'b1;
        bus.rx_enable = 1'b1;
        idle(3);
        check("rst_rx_byte", int'(bus.rx_byte), 0);
        check_note("rst", 9, 1);
        check("rst_pulses", int'({bus.rx_byte_valid, bus.framing_err, bus.note_valid, bus.parse_error}), 0);
        reset = 1'b0;
        idle(4);
        blog.delete();
        for (int i = 0; i < tbl.size(); i++) begin
            nv0 = n_nv;
            pe0 = n_pe;
            send_str(tbl[i].txt, tbl[i].term);
            check($sformatf("vec%0d_note_valid", i), n_nv - nv0, tbl[i].nv);
            check($sformatf("vec%0d_parse_error", i), n_pe - pe0, tbl[i].pe);
            check_note($sformatf("vec%0d", i), tbl[i].p, tbl[i].o);
            if (i == 1) begin
                check("byte_count", blog.size(), 5);
                for (int k = 0; k < 5 && k < blog.size(); k++)
                    check($sformatf("byte%0d", k), int'(blog[k]), int'(eb[k]));
            end
        end
        v0 = n_vld;
        f0 = n_fe;
        send_byte(8'h55, 1'b0);
        idle(2);
        check("ferr_pulse", n_fe - f0, 1);
        check("ferr_no_byte", n_vld - v0, 0);
        idle(30 * CPB);
        check("low_hold_ferr", n_fe - f0, 1);
        check("low_hold_byte", n_vld - v0, 0);
        bus.rx = 1'b1;
        idle(CPB);
        nv0 = n_nv;
        send_str("G4", 8'h0D);
        check("after_ferr_nv", n_nv - nv0, 1);
        check_note("after_ferr", 7, 1);
        pe0 = n_pe;
        nv0 = n_nv;
        send_byte("A", 1'b1);
        send_byte("4", 1'b1);
        send_byte(8'h00, 1'b0);
        bus.rx = 1'b1;
        idle(CPB);
        send_str(96'd0, 8'h0D);
        check("midline_ferr_pe", n_pe - pe0, 1);
        check("midline_ferr_nv", n_nv - nv0, 0);
        check_note("midline_ferr", 7, 1);
        v0 = n_vld;
        f0 = n_fe;
        bus.rx = 1'b0;
        idle(8);
        bus.rx = 1'b1;
        idle(3 * CPB);
        check("glitch_byte", n_vld - v0, 0);
        check("glitch_ferr", n_fe - f0, 0);
        pe0 = n_pe;
        bus.rx = 1'b0;
        idle(2 * CPB + 5);
        bus.rx_enable = 1'b0;
        idle(3);
        bus.rx = 1'b1;
        idle(2 * CPB);
        bus.rx_enable = 1'b1;
        idle(CPB);
        send_str("D5", 8'h0D);
        check("enable_drop_bytes", n_vld - v0, 3);
        check("enable_drop_ferr", n_fe - f0, 0);
        check("enable_drop_pe", n_pe - pe0, 0);
        check_note("enable_drop", 2, 2);
        send_str("F6", 8'h0D);
        check_note("pre_reset", 5, 3);
        bus.rx = 1'b0;
        idle(3 * CPB);
        reset = 1'b1;
        idle(1);
        check_note("mid_reset", 9, 1);
        check("mid_reset_byte", int'(bus.rx_byte), 0);
        check("mid_reset_pulses", int'({bus.rx_byte_valid, bus.framing_err, bus.note_valid, bus.parse_error}), 0);
        bus.rx = 1'b1;
        reset = 1'b0;
        idle(2 * CPB);
        nv0 = n_nv;
        pe0 = n_pe;
        send_str("a#6", 8'h0D);
        check("post_reset_nv", n_nv - nv0, 1);
        check("post_reset_pe", n_pe - pe0, 0);
        check_note("post_reset", 10, 3);
        evq.delete();
        mp = 10;
        mo = 3;
        for (int l = 0; l < 10; l++) begin
            logic [7:0] ln[$];
            logic ok;
            logic [3:0] p;
            logic [1:0] o;
            int t;
            if ($urandom_range(0, 7) != 0) begin
                ln.push_back(letters[$urandom_range(0, 15)]);
                t = $urandom_range(0, 3);
                if (t == 1) ln.push_back(8'h23);
                if (t == 2) ln.push_back(8'h20);
                ln.push_back(8'(8'h32 + $urandom_range(0, 5)));
                repeat ($urandom_range(0, 10)) ln.push_back(8'($urandom_range(32, 126)));
            end
            if (ln.size() > 0) begin
                model_line(ln, ok, p, o);
                expq.push_back(ok ? {1'b1, p, o} : 7'd0);
                if (ok) begin
                    mp = int'(p);
                    mo = int'(o);
                end
            end
            foreach (ln[k]) send_byte(ln[k], 1'b1);
            t = $urandom_range(0, 2);
            if (t != 1) send_byte(8'h0D, 1'b1);
            if (t != 0) send_byte(8'h0A, 1'b1);
        end
        idle(4);
        check("rand_event_count", evq.size(), expq.size());
        for (int k = 0; k < evq.size() && k < expq.size(); k++)
            check($sformatf("rand_event%0d", k), int'(evq[k]), int'(expq[k]));
        check_note("rand_final", mp, mo);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
